// File: rtl/spi_daisy_ctrl.sv
// Frame sequencer for a spi_master feeding a daisy chain of p_NUM_SLAVES devices on one slave-select.
// Sends one word per device (farthest first), gathers the returned words and presents the full frame.
module spi_daisy_ctrl #(
  parameter int unsigned p_WORD_LEN   = 8,
  parameter int unsigned p_NUM_SLAVES = 2,
  parameter int unsigned p_SS_SETUP   = 4,
  parameter int unsigned p_SS_HOLD    = 4,
  parameter int unsigned p_GAP        = 2,
  parameter int unsigned p_TIMEOUT    = 1023
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  input  logic [p_NUM_SLAVES*p_WORD_LEN-1:0] i_tx_frame,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err,
  output logic [p_NUM_SLAVES*p_WORD_LEN-1:0] o_rx_frame,
  output logic                               o_ss,
  output logic [p_WORD_LEN-1:0]              o_m_data,
  output logic                               o_m_en,
  input  logic                               i_m_rdy,
  input  logic [p_WORD_LEN-1:0]              i_m_out_data,
  input  logic                               i_m_out_rdy
);

  localparam int unsigned FrameW  = p_NUM_SLAVES * p_WORD_LEN;
  localparam int unsigned IdxW    = (p_NUM_SLAVES > 1) ? $clog2(p_NUM_SLAVES) : 1;
  localparam int unsigned CntMax0 = (p_SS_SETUP > p_SS_HOLD) ? p_SS_SETUP : p_SS_HOLD;
  localparam int unsigned CntMax  = (CntMax0 > p_GAP) ? CntMax0 : p_GAP;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned TmoW    = $clog2(p_TIMEOUT + 1);

  // SETUP plus the first LOAD cycle together span p_SS_SETUP cycles of SS low before inp_en.
  localparam logic [CntW-1:0] SetupLast = CntW'((p_SS_SETUP > 1) ? p_SS_SETUP - 2 : 0);
  localparam logic [CntW-1:0] GapLast   = CntW'((p_GAP > 0) ? p_GAP - 1 : 0);
  localparam logic [CntW-1:0] HoldLast  = CntW'(p_SS_HOLD - 1);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(p_TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(p_NUM_SLAVES - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StLoad, StAccept, StWait, StGap, StHold, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [FrameW-1:0]   tx_q, tx_d, rx_q, rx_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                flag_q, flag_d;
  logic                ss_q, ss_d, m_en_q, m_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [p_WORD_LEN-1:0] m_data_q, m_data_d;
  logic                word_done, tmo_hit;

  assign word_done = (flag_q | i_m_out_rdy) & i_m_rdy;
  assign tmo_hit   = (tmo_q == TmoLast);

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    idx_d    = idx_q;
    cnt_d    = '0;
    tmo_d    = '0;
    flag_d   = flag_q;
    ss_d     = ss_q;
    m_en_d   = m_en_q;
    m_data_d = m_data_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          tx_d    = i_tx_frame;
          rx_d    = '0;
          idx_d   = IdxLast;
          busy_d  = 1'b1;
          ss_d    = 1'b0;
          err_d   = 1'b0;
          state_d = (p_SS_SETUP > 1) ? StSetup : StLoad;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) state_d = StLoad;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      StLoad: begin
        if (i_m_rdy) begin
          m_data_d = tx_q[idx_q*p_WORD_LEN +: p_WORD_LEN];
          m_en_d   = 1'b1;
          state_d  = StAccept;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StHold;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StAccept: begin
        if (!i_m_rdy) begin
          m_en_d  = 1'b0;
          flag_d  = 1'b0;
          state_d = StWait;
        end else if (tmo_hit) begin
          m_en_d  = 1'b0;
          err_d   = 1'b1;
          state_d = StHold;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWait: begin
        if (i_m_out_rdy) begin
          flag_d = 1'b1;
          rx_d[idx_q*p_WORD_LEN +: p_WORD_LEN] = i_m_out_data;
        end
        if (word_done) begin
          if (idx_q == '0) begin
            state_d = StHold;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = (p_GAP > 0) ? StGap : StLoad;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StHold;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) state_d = StLoad;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          ss_d    = 1'b1;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      tx_q     <= '0;
      rx_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      flag_q   <= 1'b0;
      ss_q     <= 1'b1;
      m_en_q   <= 1'b0;
      m_data_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      flag_q   <= flag_d;
      ss_q     <= ss_d;
      m_en_q   <= m_en_d;
      m_data_q <= m_data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_rx_frame = rx_q;
  assign o_ss       = ss_q;
  assign o_m_data   = m_data_q;
  assign o_m_en     = m_en_q;

endmodule

// File: tb/tb_spi_daisy_ctrl.sv
// Directed bench for spi_daisy_ctrl: a spi_master stub with a two-device shift-chain behind it,
// plus a negedge monitor timing SS, inp_en and done.
module tb_spi_daisy_ctrl;

  localparam int W    = 8;
  localparam int N    = 2;
  localparam int SET  = 4;
  localparam int HOLD = 4;
  localparam int TMO  = 40;

  logic           clk, rst_n, start;
  logic [N*W-1:0] tx_frame, rx_frame;
  logic           busy, done, err, ss, m_en;
  logic [W-1:0]   m_data;
  logic           m_rdy, m_out_rdy;
  logic [W-1:0]   m_out_data;

  spi_daisy_ctrl #(
    .p_WORD_LEN  (W),
    .p_NUM_SLAVES(N),
    .p_SS_SETUP  (SET),
    .p_SS_HOLD   (HOLD),
    .p_GAP       (2),
    .p_TIMEOUT   (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_tx_frame  (tx_frame),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_rx_frame  (rx_frame),
    .o_ss        (ss),
    .o_m_data    (m_data),
    .o_m_en      (m_en),
    .i_m_rdy     (m_rdy),
    .i_m_out_data(m_out_data),
    .i_m_out_rdy (m_out_rdy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Master stub + slave chain (chain[0] = slave 1, nearest the master), and the monitor.
  logic [W-1:0]   chain [N];
  logic [W-1:0]   sent_q [$];
  logic [N*W-1:0] rx_hist [$];
  logic [W-1:0]   lat;
  logic           accept_en;
  int phase, xcnt, cyc, last_out_cyc;
  int t_ss_fall, t_ss_rise, t_men_first, t_men_rise, t_men_fall, t_done_rise;
  int ss_high_run, last_high_run, done_run, last_done_len, done_cnt;
  logic prev_ss, prev_men, prev_done, seen_men;

  initial begin
    chain[0] = 8'h00;
    chain[1] = 8'h55;
    m_rdy = 1'b1; m_out_rdy = 1'b0; m_out_data = '0; accept_en = 1'b1;
    phase = 0; xcnt = 0; cyc = 0; last_out_cyc = 0; lat = '0;
    t_ss_fall = 0; t_ss_rise = 0; t_men_first = 0; t_men_rise = 0; t_men_fall = 0; t_done_rise = 0;
    ss_high_run = 0; last_high_run = 0; done_run = 0; last_done_len = 0; done_cnt = 0;
    prev_ss = 1'b1; prev_men = 1'b0; prev_done = 1'b0; seen_men = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ss) ss_high_run++;
      if (prev_ss && !ss) begin
        t_ss_fall = cyc; last_high_run = ss_high_run; ss_high_run = 0; seen_men = 1'b0;
      end
      if (!prev_ss && ss) t_ss_rise = cyc;
      if (m_en && !prev_men) begin
        t_men_rise = cyc;
        if (!seen_men) begin t_men_first = cyc; seen_men = 1'b1; end
      end
      if (!m_en && prev_men) t_men_fall = cyc;
      if (done) done_run++;
      else begin
        if (done_run != 0) last_done_len = done_run;
        done_run = 0;
      end
      if (done && !prev_done) begin
        t_done_rise = cyc; done_cnt++; rx_hist.push_back(rx_frame);
      end
      prev_ss = ss; prev_men = m_en; prev_done = done;
      case (phase)
        0: if (accept_en && m_en && m_rdy) begin
          lat = m_data; sent_q.push_back(m_data); m_rdy = 1'b0; xcnt = 0; phase = 1;
        end
        1: begin
          xcnt++;
          if (xcnt == 6) begin
            m_out_data = chain[1]; chain[1] = chain[0]; chain[0] = lat;
            m_out_rdy = 1'b1; m_rdy = 1'b1; last_out_cyc = cyc; phase = 2;
          end
        end
        default: begin m_out_rdy = 1'b0; phase = 0; end
      endcase
    end
  end

  task automatic start_frame(input logic [N*W-1:0] tx);
    @(negedge clk);
    start = 1'b1; tx_frame = tx;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int base, n, dc;
    rst_n = 1'b1; start = 1'b0; tx_frame = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ss", ss, 1'b1);
    check_eq("rst_m_en", m_en, 1'b0);
    check_eq("rst_m_data", m_data, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_rx", rx_frame, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: AA goes out first (w1), slaves preloaded 00 / 55.
    start_frame(16'hAAFF);
    check_eq("f1_busy", busy, 1'b1);
    check_eq("f1_ss_low", ss, 1'b0);
    wait_done("f1_done", 200);
    check_eq("f1_rx", rx_frame, 16'h5500);
    check_eq("f1_err", err, 1'b0);
    check_eq("f1_ss_high_at_done", ss, 1'b1);
    check_eq("f1_sent0", sent_q[0], 8'hAA);
    check_eq("f1_sent1", sent_q[1], 8'hFF);
    check_eq("f1_setup", t_men_first - t_ss_fall, SET);
    // out_rdy driven at negedge is consumed on the following edge, then HOLD cycles.
    check_eq("f1_hold", t_ss_rise - last_out_cyc, HOLD + 1);
    @(negedge clk);
    check_eq("f1_done_len", last_done_len, 1);
    check_eq("f1_busy_clear", busy, 1'b0);

    // Frame 2: chain hands back frame 1 with matching indices.
    start_frame(16'h1122);
    wait_done("f2_done", 200);
    check_eq("f2_rx", rx_frame, 16'hAAFF);
    check_eq("f2_err", err, 1'b0);

    // Timeout: master never accepts.
    accept_en = 1'b0;
    start_frame(16'h7788);
    wait_done("to_done", 200);
    check_eq("to_err", err, 1'b1);
    check_eq("to_ss", ss, 1'b1);
    check_eq("to_rx", rx_frame, 16'h0000);
    check_eq("to_m_en_len", t_men_fall - t_men_rise, TMO);
    check_eq("to_hold", t_done_rise - t_men_fall, HOLD);
    @(negedge clk);
    check_eq("to_m_en_low", m_en, 1'b0);
    check_eq("to_err_held", err, 1'b1);
    accept_en = 1'b1;

    // Start pulse while busy is ignored.
    base = sent_q.size();
    dc = done_cnt;
    start_frame(16'h3344);
    repeat (8) @(negedge clk);
    start = 1'b1; tx_frame = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done("p5_done", 200);
    check_eq("p5_rx", rx_frame, 16'h1122);
    check_eq("p5_err_cleared", err, 1'b0);
    repeat (30) @(negedge clk);
    check_eq("p5_one_frame", done_cnt - dc, 1);
    check_eq("p5_words_sent", sent_q.size() - base, 2);
    check_eq("p5_idle", busy, 1'b0);

    // Start held high: two frames back to back.
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1; tx_frame = 16'h5AA5;
    wait_done("b2b_done_a", 200);
    @(negedge clk);
    wait_done("b2b_done_b", 200);
    start = 1'b0;
    check_eq("b2b_rx_a", rx_hist[rx_hist.size()-2], 16'h3344);
    check_eq("b2b_rx_b", rx_frame, 16'h5AA5);
    check_eq("b2b_ss_gap", last_high_run >= 1, 1'b1);
    repeat (30) @(negedge clk);
    check_eq("b2b_two_frames", done_cnt - dc, 2);

    // Reset during the second word's WAIT.
    base = sent_q.size();
    start_frame(16'hC33C);
    n = 0;
    while (sent_q.size() < base + 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst6_word2_started", sent_q.size() - base, 2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst6_ss", ss, 1'b1);
    check_eq("rst6_m_en", m_en, 1'b0);
    check_eq("rst6_busy", busy, 1'b0);
    check_eq("rst6_rx", rx_frame, 16'h0000);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    // Interrupted word still completed in the chain: slave 2 = C3, slave 1 = 3C.
    start_frame(16'h0102);
    wait_done("rst6_next_done", 200);
    check_eq("rst6_next_rx", rx_frame, 16'hC33C);
    check_eq("rst6_next_err", err, 1'b0);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
